// File: rtl/m2764a_dut_emul.sv
// Device-side M2764A EPROM emulator: synchronises the programmer's pins to osc_in and answers
// read/verify, program-pulse, inhibit and UV-erase cycles against an internal 2**ADDR_W x 8 array.
module m2764a_dut_emul #(
  parameter int ADDR_W          = 13,
  parameter int TICKS_PER_MS    = 24000,
  parameter int MIN_PULSE_TICKS = 2400,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              osc_in,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pin_addr,
  input  logic [7:0]        pin_dq_in,
  input  logic              pin_e_n,
  input  logic              pin_g_n,
  input  logic              pin_p_n,
  input  logic              pin_vpp,
  input  logic              erase,
  input  logic              err_clr,
  output logic [7:0]        dq_out,
  output logic              dq_oe,
  output logic              busy,
  output logic [15:0]       prog_count,
  output logic [7:0]        pulse_ms,
  output logic              err_short,
  output logic              err_vpp,
  output logic              err_unstab
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SUB_W = $clog2(TICKS_PER_MS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_PULSE, S_COMMIT_RD, S_COMMIT_WR, S_ERASE
  } state_t;

  // pin synchronisers
  logic [SYNC_STAGES-1:0][ADDR_W-1:0] r_s_addr;
  logic [SYNC_STAGES-1:0][7:0]        r_s_dq;
  logic [SYNC_STAGES-1:0]             r_s_e, r_s_g, r_s_p, r_s_vpp;

  always_ff @(posedge osc_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s_addr <= '0;
      r_s_dq   <= '0;
      r_s_e    <= '1;
      r_s_g    <= '1;
      r_s_p    <= '1;
      r_s_vpp  <= '0;
    end else begin
      r_s_addr <= {r_s_addr[SYNC_STAGES-2:0], pin_addr};
      r_s_dq   <= {r_s_dq[SYNC_STAGES-2:0], pin_dq_in};
      r_s_e    <= {r_s_e[SYNC_STAGES-2:0], pin_e_n};
      r_s_g    <= {r_s_g[SYNC_STAGES-2:0], pin_g_n};
      r_s_p    <= {r_s_p[SYNC_STAGES-2:0], pin_p_n};
      r_s_vpp  <= {r_s_vpp[SYNC_STAGES-2:0], pin_vpp};
    end
  end

  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_dq;
  logic              w_e_n, w_g_n, w_p_n, w_vpp;

  assign w_addr = r_s_addr[SYNC_STAGES-1];
  assign w_dq   = r_s_dq[SYNC_STAGES-1];
  assign w_e_n  = r_s_e[SYNC_STAGES-1];
  assign w_g_n  = r_s_g[SYNC_STAGES-1];
  assign w_p_n  = r_s_p[SYNC_STAGES-1];
  assign w_vpp  = r_s_vpp[SYNC_STAGES-1];

  state_t            r_state, w_state_nx;
  logic [7:0]        r_dq, w_dq_nx;
  logic              r_oe, w_oe_nx;
  logic [ADDR_W-1:0] r_lat_addr, w_lat_addr_nx;
  logic [7:0]        r_lat_data, w_lat_data_nx;
  logic [7:0]        r_old, w_old_nx;
  logic [23:0]       r_ticks, w_ticks_nx, w_ticks_inc;
  logic [SUB_W-1:0]  r_sub, w_sub_nx, w_sub_inc;
  logic [7:0]        r_ms, w_ms_nx, w_ms_inc;
  logic [7:0]        r_pulse_ms, w_pulse_ms_nx;
  logic [15:0]       r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0] r_ecnt, w_ecnt_nx;
  logic              r_pend, r_erase_d, w_erase_rise, w_pend_clr;
  logic              r_err_short, r_err_vpp, r_err_unstab;
  logic              w_set_short, w_set_vpp, w_set_unstab;
  logic              w_sub_wrap;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] w_rd_addr, w_wa;
  logic [7:0]        w_rd_data, w_wd;
  logic              w_we;

  // single read port: commit reads the latched address, everything else the live pins
  assign w_rd_addr = (r_state == S_COMMIT_RD) ? r_lat_addr : w_addr;
  assign w_rd_data = r_mem[w_rd_addr];

  assign w_we = (r_state == S_COMMIT_WR) || (r_state == S_ERASE);
  assign w_wa = (r_state == S_ERASE) ? r_ecnt : r_lat_addr;
  assign w_wd = (r_state == S_ERASE) ? 8'hFF : (r_old & r_lat_data);

  always_ff @(posedge osc_in) begin
    if (w_we) r_mem[w_wa] <= w_wd;
  end

  // pulse timing: saturating raw tick count plus a wrapping sub-ms counter feeding ms
  assign w_ticks_inc = (r_ticks == 24'hFF_FFFF) ? r_ticks : r_ticks + 24'd1;
  assign w_sub_wrap  = (r_sub == SUB_W'(TICKS_PER_MS - 1));
  assign w_sub_inc   = w_sub_wrap ? '0 : r_sub + SUB_W'(1);
  assign w_ms_inc    = (w_sub_wrap && r_ms != 8'hFF) ? r_ms + 8'd1 : r_ms;

  assign w_erase_rise = erase & ~r_erase_d;

  always_comb begin
    w_state_nx    = r_state;
    w_oe_nx       = 1'b0;
    w_dq_nx       = r_dq;
    w_lat_addr_nx = r_lat_addr;
    w_lat_data_nx = r_lat_data;
    w_old_nx      = r_old;
    w_ticks_nx    = r_ticks;
    w_sub_nx      = r_sub;
    w_ms_nx       = r_ms;
    w_pulse_ms_nx = r_pulse_ms;
    w_cnt_nx      = r_cnt;
    w_ecnt_nx     = r_ecnt;
    w_pend_clr    = 1'b0;
    w_set_short   = 1'b0;
    w_set_vpp     = 1'b0;
    w_set_unstab  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_state_nx = S_ERASE;
          w_ecnt_nx  = '0;
        end else if (!w_e_n && !w_g_n) begin
          w_state_nx = S_READ;
          w_oe_nx    = 1'b1;
          w_dq_nx    = w_rd_data;
        end else if (!w_e_n && w_g_n && !w_p_n && w_vpp) begin
          w_state_nx    = S_PULSE;
          w_lat_addr_nx = w_addr;
          w_lat_data_nx = w_dq;
          w_ticks_nx    = '0;
          w_sub_nx      = '0;
          w_ms_nx       = '0;
        end
      end
      S_READ: begin
        if (!w_e_n && !w_g_n) begin
          w_oe_nx = 1'b1;
          w_dq_nx = w_rd_data;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_PULSE: begin
        w_ticks_nx = w_ticks_inc;
        w_sub_nx   = w_sub_inc;
        w_ms_nx    = w_ms_inc;
        if (!w_vpp) begin
          w_set_vpp  = 1'b1;
          w_state_nx = S_IDLE;
        end else if (w_addr != r_lat_addr || w_dq != r_lat_data) begin
          w_set_unstab = 1'b1;
          w_state_nx   = S_IDLE;
        end else if (w_p_n || w_e_n) begin
          w_pulse_ms_nx = w_ms_inc;
          if (w_ticks_inc < 24'(MIN_PULSE_TICKS)) begin
            w_set_short = 1'b1;
            w_state_nx  = S_IDLE;
          end else begin
            w_state_nx = S_COMMIT_RD;
          end
        end
      end
      S_COMMIT_RD: begin
        w_old_nx   = w_rd_data;
        w_state_nx = S_COMMIT_WR;
      end
      S_COMMIT_WR: begin
        w_cnt_nx   = r_cnt + 16'd1;
        w_state_nx = S_IDLE;
      end
      S_ERASE: begin
        w_ecnt_nx = r_ecnt + ADDR_W'(1);
        if (r_ecnt == {ADDR_W{1'b1}}) begin
          w_pend_clr = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge osc_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_dq         <= '0;
      r_oe         <= 1'b0;
      r_lat_addr   <= '0;
      r_lat_data   <= '0;
      r_old        <= '0;
      r_ticks      <= '0;
      r_sub        <= '0;
      r_ms         <= '0;
      r_pulse_ms   <= '0;
      r_cnt        <= '0;
      r_ecnt       <= '0;
      r_pend       <= 1'b0;
      r_erase_d    <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_vpp    <= 1'b0;
      r_err_unstab <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_dq         <= w_dq_nx;
      r_oe         <= w_oe_nx;
      r_lat_addr   <= w_lat_addr_nx;
      r_lat_data   <= w_lat_data_nx;
      r_old        <= w_old_nx;
      r_ticks      <= w_ticks_nx;
      r_sub        <= w_sub_nx;
      r_ms         <= w_ms_nx;
      r_pulse_ms   <= w_pulse_ms_nx;
      r_cnt        <= w_cnt_nx;
      r_ecnt       <= w_ecnt_nx;
      r_erase_d    <= erase;
      // a new request or a fresh error outranks the same-cycle clear
      r_pend       <= w_erase_rise | (r_pend & ~w_pend_clr);
      r_err_short  <= w_set_short  | (r_err_short  & ~err_clr);
      r_err_vpp    <= w_set_vpp    | (r_err_vpp    & ~err_clr);
      r_err_unstab <= w_set_unstab | (r_err_unstab & ~err_clr);
    end
  end

  assign dq_out     = r_dq;
  assign dq_oe      = r_oe;
  assign busy       = (r_state == S_ERASE) || (r_state == S_COMMIT_RD) || (r_state == S_COMMIT_WR);
  assign prog_count = r_cnt;
  assign pulse_ms   = r_pulse_ms;
  assign err_short  = r_err_short;
  assign err_vpp    = r_err_vpp;
  assign err_unstab = r_err_unstab;

endmodule

// File: tb/tb_m2764a_dut_emul.sv
// Directed bench for the M2764A emulator: a byte-array EPROM model updated per transaction,
// compared against the DUT every idle cycle, plus explicit read-latency and literal checks.
module tb_m2764a_dut_emul;

  logic        osc_in = 1'b0;
  logic        rst_n;
  logic [12:0] pin_addr;
  logic [7:0]  pin_dq_in;
  logic        pin_e_n, pin_g_n, pin_p_n, pin_vpp, erase, err_clr;
  logic [7:0]  dq_out;
  logic        dq_oe, busy;
  logic [15:0] prog_count;
  logic [7:0]  pulse_ms;
  logic        err_short, err_vpp, err_unstab;

  m2764a_dut_emul dut (
    .osc_in(osc_in), .rst_n(rst_n), .pin_addr(pin_addr), .pin_dq_in(pin_dq_in),
    .pin_e_n(pin_e_n), .pin_g_n(pin_g_n), .pin_p_n(pin_p_n), .pin_vpp(pin_vpp),
    .erase(erase), .err_clr(err_clr), .dq_out(dq_out), .dq_oe(dq_oe), .busy(busy),
    .prog_count(prog_count), .pulse_ms(pulse_ms), .err_short(err_short),
    .err_vpp(err_vpp), .err_unstab(err_unstab)
  );

  always #5 osc_in = ~osc_in;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural device model
  logic [7:0] m_mem [8192];
  int         m_cnt, m_pulse;
  bit         m_es, m_ev, m_eu;
  bit         m_valid = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge osc_in);
    #1;
  endtask

  always @(negedge osc_in) begin
    if (m_valid && rst_n) begin
      chk("cmp_busy", int'(busy), 0);
      chk("cmp_dq_oe", int'(dq_oe), 0);
      chk("cmp_prog_count", int'(prog_count), m_cnt);
      chk("cmp_pulse_ms", int'(pulse_ms), m_pulse);
      chk("cmp_err_short", int'(err_short), int'(m_es));
      chk("cmp_err_vpp", int'(err_vpp), int'(m_ev));
      chk("cmp_err_unstab", int'(err_unstab), int'(m_eu));
    end
  end

  // mode 0: normal pulse of len cycles, 1: VPP drop after len, 2: A0 toggle after len, 3: inhibit (VPP=0)
  task automatic do_pulse(input logic [12:0] a, input logic [7:0] d, input int len,
                          input int mode, input bit clr_at_set);
    int ms;
    m_valid = 1'b0;
    tick(1);
    pin_addr = a; pin_dq_in = d; pin_e_n = 1'b0; pin_g_n = 1'b1; pin_p_n = 1'b1;
    pin_vpp = (mode != 3);
    tick(4);
    pin_p_n = 1'b0;
    tick(len);
    if (mode == 1) begin pin_vpp = 1'b0; tick(1); end
    else if (mode == 2) begin pin_addr = a ^ 13'd1; tick(1); end
    pin_p_n = 1'b1;
    if (clr_at_set) begin tick(2); err_clr = 1'b1; tick(1); err_clr = 1'b0; end
    tick(6);
    pin_e_n = 1'b1; pin_vpp = 1'b0;
    if (clr_at_set) begin m_es = 0; m_ev = 0; m_eu = 0; end
    case (mode)
      0: begin
        ms = len / 24000;
        m_pulse = (ms > 255) ? 255 : ms;
        if (len < 2400) m_es = 1;
        else begin
          m_mem[a] = m_mem[a] & d;
          m_cnt = (m_cnt + 1) & 'hFFFF;
        end
      end
      1: m_ev = 1;
      2: m_eu = 1;
      default: ;
    endcase
    tick(4);
    m_valid = 1'b1;
    tick(8);
  endtask

  task automatic rd(input logic [12:0] a, input logic vpp);
    m_valid = 1'b0;
    tick(1);
    pin_addr = a; pin_e_n = 1'b0; pin_g_n = 1'b0; pin_vpp = vpp;
    @(posedge osc_in); @(posedge osc_in); @(negedge osc_in);
    chk("rd_oe_at_cycle2", int'(dq_oe), 0);
    @(negedge osc_in);
    chk("rd_oe_at_cycle3", int'(dq_oe), 1);
    chk("rd_data", int'(dq_out), int'(m_mem[a]));
    tick(1);
    pin_g_n = 1'b1; pin_e_n = 1'b1; pin_vpp = 1'b0;
    @(posedge osc_in); @(posedge osc_in); @(negedge osc_in);
    chk("rd_oe_hold", int'(dq_oe), 1);
    @(negedge osc_in);
    chk("rd_oe_release", int'(dq_oe), 0);
    tick(2);
    m_valid = 1'b1;
    tick(4);
  endtask

  task automatic clr_errs();
    m_valid = 1'b0;
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_es = 0; m_ev = 0; m_eu = 0;
    tick(1);
    m_valid = 1'b1;
    tick(4);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int w, c;
    rst_n = 1'b0;
    pin_addr = '0; pin_dq_in = '0; pin_e_n = 1'b1; pin_g_n = 1'b1; pin_p_n = 1'b1;
    pin_vpp = 1'b0; erase = 1'b0; err_clr = 1'b0;
    m_cnt = 0; m_pulse = 0; m_es = 0; m_ev = 0; m_eu = 0;
    for (int i = 0; i < 8192; i++) m_mem[i] = 8'hFF;
    repeat (3) @(negedge osc_in);
    chk("rst_dq_out", int'(dq_out), 0);
    chk("rst_dq_oe", int'(dq_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_prog_count", int'(prog_count), 0);
    chk("rst_pulse_ms", int'(pulse_ms), 0);
    chk("rst_errs", int'({err_short, err_vpp, err_unstab}), 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    m_valid = 1'b1;
    tick(4);

    // 1: full erase
    m_valid = 1'b0;
    erase = 1'b1;
    tick(1);
    erase = 1'b0;
    w = 0;
    @(negedge osc_in);
    while (!busy && w < 20) begin w++; @(negedge osc_in); end
    chk("erase_busy_rise", int'(busy), 1);
    c = 0;
    while (busy && c < 9000) begin c++; @(negedge osc_in); end
    chk("erase_busy_cycles", c, 8192);
    tick(2);
    m_valid = 1'b1;
    tick(4);
    rd(13'h0000, 1'b0);
    rd(13'h1FFF, 1'b0);
    chk("lit_erased_1fff", int'(m_mem[13'h1FFF]), 'hFF);

    // 2: program 0x0123 = 0xA5 for exactly 1 ms, read and verify
    do_pulse(13'h0123, 8'hA5, 24000, 0, 1'b0);
    chk("lit_prog_count_1", int'(prog_count), 1);
    chk("lit_pulse_ms_1", int'(pulse_ms), 1);
    chk("lit_model_a5", int'(m_mem[13'h0123]), 'hA5);
    rd(13'h0123, 1'b0);
    rd(13'h0123, 1'b1);

    // 3: bits only clear
    do_pulse(13'h0123, 8'h5A, 24000, 0, 1'b0);
    chk("lit_prog_count_2", int'(prog_count), 2);
    chk("lit_model_00", int'(m_mem[13'h0123]), 'h00);
    rd(13'h0123, 1'b0);

    // 4: short pulses, threshold boundary, clear vs set priority
    do_pulse(13'h0124, 8'h00, 100, 0, 1'b0);
    chk("lit_err_short_100", int'(err_short), 1);
    rd(13'h0124, 1'b0);
    clr_errs();
    chk("lit_err_short_cleared", int'(err_short), 0);
    do_pulse(13'h0124, 8'h00, 2399, 0, 1'b1);
    chk("lit_err_short_set_wins", int'(err_short), 1);
    clr_errs();
    do_pulse(13'h0200, 8'hF0, 2400, 0, 1'b0);
    chk("lit_prog_count_min", int'(prog_count), 3);
    chk("lit_pulse_ms_0", int'(pulse_ms), 0);
    rd(13'h0200, 1'b0);

    // 5: VPP drop, unstable address, program inhibit
    do_pulse(13'h0400, 8'h00, 500, 1, 1'b0);
    chk("lit_err_vpp", int'(err_vpp), 1);
    do_pulse(13'h0401, 8'h00, 500, 2, 1'b0);
    chk("lit_err_unstab", int'(err_unstab), 1);
    do_pulse(13'h0500, 8'h00, 3000, 3, 1'b0);
    rd(13'h0400, 1'b0);
    rd(13'h0401, 1'b0);
    rd(13'h0500, 1'b0);
    chk("lit_prog_count_3", int'(prog_count), 3);

    // 6: reset in the middle of a pulse
    m_valid = 1'b0;
    tick(1);
    pin_addr = 13'h0300; pin_dq_in = 8'h00; pin_e_n = 1'b0; pin_g_n = 1'b1; pin_vpp = 1'b1;
    tick(4);
    pin_p_n = 1'b0;
    tick(5000);
    rst_n = 1'b0;
    @(negedge osc_in);
    chk("midrst_dq_out", int'(dq_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_prog_count", int'(prog_count), 0);
    chk("midrst_errs", int'({err_short, err_vpp, err_unstab}), 0);
    tick(1);
    pin_p_n = 1'b1; pin_e_n = 1'b1; pin_vpp = 1'b0;
    tick(3);
    rst_n = 1'b1;
    m_cnt = 0; m_pulse = 0; m_es = 0; m_ev = 0; m_eu = 0;
    tick(4);
    m_valid = 1'b1;
    tick(8);
    rd(13'h0300, 1'b0);
    rd(13'h0200, 1'b0);
    rd(13'h0123, 1'b0);
    chk("lit_survive_f0", int'(m_mem[13'h0200]), 'hF0);

    m_valid = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
